// File: rtl/controller_defs.sv
// Shared definitions for the RV32I controllers (single-cycle and multi-cycle).
// Contents:
//   - opcode constants for the supported instruction classes
//   - state_t: multi-cycle FSM state encodings (visible on the debug port)
//   - alu_src_a / alu_src_b mux select codes
//   - alu_op codes handed to the ALU decoder
//   - is_retire_state(): states whose exit completes an instruction
package controller_defs;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9
    } state_t;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_RFUNCT  = 2'b10;
    localparam logic [1:0] ALU_IFUNCT  = 2'b11;

    // MEM_WR is excluded: it only retires once memory accepts the write.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEM_WB) || (s == S_ALU_WB) || (s == S_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle Moore controller for the RV32I datapath.
// Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB, drives the
// shared ALU, register file and unified memory, and counts retired instructions.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   opcode              : instr[6:0] from the instruction register
//   zero                : ALU zero flag (branch decision)
//   mem_ready           : memory access completes this cycle
//   pc_write, ir_write  : PC / IR load enables
//   iord                : memory address select (0=PC, 1=ALU result)
//   mem_read, mem_write : memory strobes
//   reg_write           : register-file write enable
//   mem_to_reg          : writeback select (1=memory, 0=ALU)
//   alu_src_a/b, alu_op : ALU operand selects and operation class
//   branch              : high in the BRANCH state
//   illegal             : one-cycle pulse on an unsupported opcode in DECODE
//   instret             : retired-instruction counter (wraps silently)
//   state               : current state encoding, for debug
module multicycle_controller
    import controller_defs::*;
#(
    parameter int unsigned USE_MEM_READY = 1,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned ST_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [ST_W-1:0]  state
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instret;
    logic             w_mem_ready;
    logic             w_retire;

    logic w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write, w_illegal;

    assign w_mem_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // Next-state logic. w_retire marks the edge that completes an instruction.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH:   if (w_mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:              w_next_state = S_EXEC_R;
                    OP_I:              w_next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE: w_next_state = S_MEM_ADR;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            // The IR holds the opcode stable, so it can be re-examined here.
            S_MEM_ADR: w_next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (w_mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WR: begin
                if (w_mem_ready) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: w_next_state = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH: begin
                w_next_state = S_FETCH;
                w_retire     = is_retire_state(r_state);
            end
            default:   w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Moore output decode; only the FETCH enables, BRANCH pc_write and the
    // DECODE illegal flag look at inputs.
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        iord        = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_ADD;
        branch      = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                w_pc_write = w_mem_ready;
                w_ir_write = w_mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                w_illegal = !(opcode == OP_R || opcode == OP_I || opcode == OP_LOAD ||
                              opcode == OP_STORE || opcode == OP_BRANCH);
            end
            S_MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                iord       = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                iord        = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_RFUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_IFUNCT;
            end
            S_ALU_WB:  w_reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                w_pc_write = zero;
            end
            default: ;
        endcase
    end

    // Reset masks every strobe so nothing is written while reset is held.
    assign pc_write  = w_pc_write  & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign mem_read  = w_mem_read  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign illegal   = w_illegal   & ~reset;

    assign instret = r_instret;
    assign state   = ST_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    // main instance (CNT_W=32)
    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        branch, illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    // narrow counter instance (CNT_W=4)
    logic        n4_pc_write, n4_ir_write, n4_iord, n4_mem_read, n4_mem_write;
    logic        n4_reg_write, n4_mem_to_reg, n4_branch, n4_illegal;
    logic [1:0]  n4_alu_src_a, n4_alu_src_b, n4_alu_op;
    logic [3:0]  n4_instret;
    logic [3:0]  n4_state;

    // instance that ignores mem_ready
    logic        nr_pc_write, nr_ir_write, nr_iord, nr_mem_read, nr_mem_write;
    logic        nr_reg_write, nr_mem_to_reg, nr_branch, nr_illegal;
    logic [1:0]  nr_alu_src_a, nr_alu_src_b, nr_alu_op;
    logic [31:0] nr_instret;
    logic [3:0]  nr_state;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.USE_MEM_READY(1), .CNT_W(32), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .branch(branch), .illegal(illegal), .instret(instret), .state(state)
    );

    multicycle_controller #(.USE_MEM_READY(1), .CNT_W(4), .ST_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(n4_pc_write), .ir_write(n4_ir_write), .iord(n4_iord), .mem_read(n4_mem_read),
        .mem_write(n4_mem_write), .reg_write(n4_reg_write), .mem_to_reg(n4_mem_to_reg),
        .alu_src_a(n4_alu_src_a), .alu_src_b(n4_alu_src_b), .alu_op(n4_alu_op),
        .branch(n4_branch), .illegal(n4_illegal), .instret(n4_instret), .state(n4_state)
    );

    multicycle_controller #(.USE_MEM_READY(0), .CNT_W(32), .ST_W(4)) dut_nr (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(nr_pc_write), .ir_write(nr_ir_write), .iord(nr_iord), .mem_read(nr_mem_read),
        .mem_write(nr_mem_write), .reg_write(nr_reg_write), .mem_to_reg(nr_mem_to_reg),
        .alu_src_a(nr_alu_src_a), .alu_src_b(nr_alu_src_b), .alu_op(nr_alu_op),
        .branch(nr_branch), .illegal(nr_illegal), .instret(nr_instret), .state(nr_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1; opcode = OPC_R; mem_ready = 1'b1; zero = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        step();
        step();
        reset = 1'b0;
        settle();

        // ---------------- R-type: 0,1,6,8,0 ----------------
        chk("r_fetch_state", 32'(state), 32'd0);
        chk("r_fetch_mem_read", 32'(mem_read), 32'd1);
        chk("r_fetch_pc_write", 32'(pc_write), 32'd1);
        chk("r_fetch_ir_write", 32'(ir_write), 32'd1);
        chk("r_fetch_reg_write", 32'(reg_write), 32'd0);
        step(); settle();
        chk("r_dec_state", 32'(state), 32'd1);
        chk("r_dec_src_a", 32'(alu_src_a), 32'd1);
        chk("r_dec_src_b", 32'(alu_src_b), 32'd2);
        chk("r_dec_reg_write", 32'(reg_write), 32'd0);
        step(); settle();
        chk("r_exec_state", 32'(state), 32'd6);
        chk("r_exec_alu_op", 32'(alu_op), 32'd2);
        chk("r_exec_src_a", 32'(alu_src_a), 32'd2);
        chk("r_exec_src_b", 32'(alu_src_b), 32'd0);
        chk("r_exec_reg_write", 32'(reg_write), 32'd0);
        step(); settle();
        chk("r_wb_state", 32'(state), 32'd8);
        chk("r_wb_reg_write", 32'(reg_write), 32'd1);
        chk("r_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
        chk("r_wb_instret_pre", instret, 32'd0);
        step(); settle();
        chk("r_done_state", 32'(state), 32'd0);
        chk("r_done_instret", instret, 32'd1);

        // ---------------- load with 2 stall cycles in MEM_RD (7 cycles) ----------------
        opcode = OPC_LD; settle();
        step(); settle();
        chk("ld_dec_state", 32'(state), 32'd1);
        step(); settle();
        chk("ld_adr_state", 32'(state), 32'd2);
        chk("ld_adr_src_a", 32'(alu_src_a), 32'd2);
        chk("ld_adr_src_b", 32'(alu_src_b), 32'd2);
        step(); mem_ready = 1'b0; settle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_ready = 1'b1; settle(); end
            chk($sformatf("ld_rd%0d_state", i), 32'(state), 32'd3);
            chk($sformatf("ld_rd%0d_mem_read", i), 32'(mem_read), 32'd1);
            chk($sformatf("ld_rd%0d_iord", i), 32'(iord), 32'd1);
            step(); settle();
        end
        chk("ld_wb_state", 32'(state), 32'd4);
        chk("ld_wb_reg_write", 32'(reg_write), 32'd1);
        chk("ld_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        step(); settle();
        chk("ld_done_state", 32'(state), 32'd0);
        chk("ld_done_instret", instret, 32'd2);

        // ---------------- FETCH stall ----------------
        opcode = OPC_ST; mem_ready = 1'b0; settle();
        chk("fst_pc_write", 32'(pc_write), 32'd0);
        chk("fst_ir_write", 32'(ir_write), 32'd0);
        chk("fst_mem_read", 32'(mem_read), 32'd1);
        step(); mem_ready = 1'b1; settle();
        chk("fst_hold_state", 32'(state), 32'd0);
        chk("fst_go_ir_write", 32'(ir_write), 32'd1);

        // ---------------- store: mem_write exactly in MEM_WR ----------------
        chk("st_fetch_mem_write", 32'(mem_write), 32'd0);
        step(); settle();
        chk("st_dec_mem_write", 32'(mem_write), 32'd0);
        step(); settle();
        chk("st_adr_mem_write", 32'(mem_write), 32'd0);
        step(); settle();
        chk("st_wr_state", 32'(state), 32'd5);
        chk("st_wr_mem_write", 32'(mem_write), 32'd1);
        chk("st_wr_iord", 32'(iord), 32'd1);
        step(); settle();
        chk("st_done_state", 32'(state), 32'd0);
        chk("st_done_mem_write", 32'(mem_write), 32'd0);
        chk("st_done_instret", instret, 32'd3);

        // ---------------- branch taken / not taken ----------------
        for (int t = 0; t < 2; t++) begin
            opcode = OPC_BR; zero = (t == 0); settle();
            step(); settle();
            chk($sformatf("br%0d_dec_pc_write", t), 32'(pc_write), 32'd0);
            step(); settle();
            chk($sformatf("br%0d_state", t), 32'(state), 32'd9);
            chk($sformatf("br%0d_branch", t), 32'(branch), 32'd1);
            chk($sformatf("br%0d_alu_op", t), 32'(alu_op), 32'd1);
            chk($sformatf("br%0d_pc_write", t), 32'(pc_write), (t == 0) ? 32'd1 : 32'd0);
            step(); settle();
            chk($sformatf("br%0d_done_state", t), 32'(state), 32'd0);
            chk($sformatf("br%0d_done_branch", t), 32'(branch), 32'd0);
            chk($sformatf("br%0d_instret", t), instret, 32'd4 + 32'(t));
        end
        zero = 1'b0;

        // ---------------- illegal opcode ----------------
        opcode = OPC_BAD; settle();
        chk("ill_fetch_illegal", 32'(illegal), 32'd0);
        step(); settle();
        chk("ill_dec_state", 32'(state), 32'd1);
        chk("ill_dec_illegal", 32'(illegal), 32'd1);
        step(); settle();
        chk("ill_next_state", 32'(state), 32'd0);
        chk("ill_next_illegal", 32'(illegal), 32'd0);
        chk("ill_instret", instret, 32'd5);

        // ---------------- 16 I-type with a 4-bit counter wraps ----------------
        reset = 1'b1; settle();
        chk("wrap_rst_instret4", 32'(n4_instret), 32'd0);
        step();
        reset = 1'b0; opcode = OPC_I; mem_ready = 1'b1; settle();
        for (int k = 0; k < 16; k++) begin
            step(); step(); settle();
            if (k == 0) begin
                chk("i_exec_state", 32'(state), 32'd7);
                chk("i_exec_alu_op", 32'(alu_op), 32'd3);
                chk("i_exec_src_b", 32'(alu_src_b), 32'd2);
            end
            step(); step(); settle();
            if (k == 14) chk("wrap_pre_instret4", 32'(n4_instret), 32'd15);
        end
        chk("wrap_instret4", 32'(n4_instret), 32'd0);
        chk("wrap_instret32", instret, 32'd16);
        chk("wrap_state", 32'(state), 32'd0);

        // ---------------- reset during stalled MEM_WR ----------------
        opcode = OPC_ST; settle();
        step(); step(); step();
        mem_ready = 1'b0; settle();
        chk("rw_wr_state", 32'(state), 32'd5);
        chk("rw_wr_mem_write", 32'(mem_write), 32'd1);
        step(); settle();
        chk("rw_hold_state", 32'(state), 32'd5);
        chk("rw_hold_mem_write", 32'(mem_write), 32'd1);
        chk("rw_hold_instret", instret, 32'd16);
        reset = 1'b1; settle();
        chk("rw_rst_state", 32'(state), 32'd0);
        chk("rw_rst_mem_write", 32'(mem_write), 32'd0);
        chk("rw_rst_instret", instret, 32'd0);
        step(); settle();
        chk("rw_rst_edge_mem_write", 32'(mem_write), 32'd0);
        reset = 1'b0; opcode = OPC_R; settle();
        chk("rw_rel_pc_write", 32'(pc_write), 32'd0);
        chk("nr_fetch_pc_write", 32'(nr_pc_write), 32'd1);
        step(); settle();
        chk("rw_rel_stall_state", 32'(state), 32'd0);
        chk("nr_state_decode", 32'(nr_state), 32'd1);
        mem_ready = 1'b1; settle();
        chk("rw_rel_ir_write", 32'(ir_write), 32'd1);
        step(); settle();
        chk("rw_resume_state", 32'(state), 32'd1);
        step(); step(); step(); settle();
        chk("rw_resume_done_state", 32'(state), 32'd0);
        chk("rw_resume_instret", instret, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
